// File: rtl/cam_pkg.sv
// Shared constants and types for the camera capture path.
// Output formats, FSM encoding and decimated geometry helpers.
package cam_pkg;

    localparam int FMT_RGB332 = 8;
    localparam int FMT_RGB444 = 12;
    localparam int FMT_RGB565 = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } cam_state_e;

    function automatic int out_w(input int h_act, input int dec_log2);
        return h_act >> dec_log2;
    endfunction

    function automatic int out_h(input int v_act, input int dec_log2);
        return v_act >> dec_log2;
    endfunction

endpackage

// File: rtl/px_fmt_conv.sv
// Combinational RGB565 to DW-bit pixel converter.
// Shared by the capture path and the VGA test-pattern path.
module px_fmt_conv
    import cam_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [15:0]   pix_i,
    output logic [DW-1:0] pix_o
);

    if (DW == FMT_RGB332) begin : g_332
        logic unused_lsb;
        assign unused_lsb = ^{pix_i[12:11], pix_i[7:5], pix_i[2:0]};
        assign pix_o = {pix_i[15:13], pix_i[10:8], pix_i[4:3]};
    end else if (DW == FMT_RGB444) begin : g_444
        logic unused_lsb;
        assign unused_lsb = ^{pix_i[11], pix_i[6:5], pix_i[0]};
        assign pix_o = {pix_i[15:12], pix_i[10:7], pix_i[4:1]};
    end else if (DW == FMT_RGB565) begin : g_565
        assign pix_o = pix_i;
    end else begin : g_bad_dw
        $error("px_fmt_conv: DW must be 8, 12 or 16");
        logic unused_pix;
        assign unused_pix = ^pix_i;
        assign pix_o = '0;
    end

endmodule

// File: rtl/cam_capture_px.sv
// OV7670-style pixel capture: byte pairing, format conversion,
// optional decimation and frame-buffer write with error reporting.
module cam_capture_px
    import cam_pkg::*;
#(
    parameter int AW       = 15,
    parameter int DW       = 8,
    parameter int H_ACT    = 160,
    parameter int V_ACT    = 120,
    parameter int DEC_LOG2 = 0
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    input  logic          en,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic          frame_err
);

    localparam int OUT_W = out_w(H_ACT, DEC_LOG2);
    localparam int OUT_H = out_h(V_ACT, DEC_LOG2);
    localparam int CAP   = OUT_W * OUT_H;
    localparam int XW    = $clog2(H_ACT + 2);
    localparam int YW    = $clog2(V_ACT + 2);

    localparam logic [AW:0]   CAP_A = (AW + 1)'(CAP);
    localparam logic [XW-1:0] X_ACT = XW'(H_ACT);
    localparam logic [XW-1:0] X_MAX = XW'(H_ACT + 1);
    localparam logic [XW-1:0] X_MSK = XW'((1 << DEC_LOG2) - 1);
    localparam logic [YW-1:0] Y_ACT = YW'(V_ACT);
    localparam logic [YW-1:0] Y_MAX = YW'(V_ACT + 1);
    localparam logic [YW-1:0] Y_MSK = YW'((1 << DEC_LOG2) - 1);

    if (DEC_LOG2 < 0 || DEC_LOG2 > 2) begin : g_bad_dec
        $error("cam_capture_px: DEC_LOG2 must be 0, 1 or 2");
    end
    if (CAP > (1 << AW)) begin : g_bad_cap
        $error("cam_capture_px: output frame exceeds address space");
    end

    cam_state_e    state_q, state_d;
    logic          vs_q, hr_q;
    logic          phase_q, phase_d;
    logic [7:0]    hi_q, hi_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [AW:0]   addr_q, addr_d;
    logic          err_q, err_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] oaddr_q, oaddr_d;
    logic [DW-1:0] odata_q, odata_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;

    logic          fr_start, fr_end, ln_end, keep;
    logic [DW-1:0] conv_pix;

    px_fmt_conv #(.DW(DW)) u_conv (
        .pix_i ({hi_q, px_data}),
        .pix_o (conv_pix)
    );

    assign fr_start = vs_q & ~vsync;
    assign fr_end   = ~vs_q & vsync;
    assign ln_end   = hr_q & ~href;

    assign keep = ((x_q & X_MSK) == '0) && ((y_q & Y_MSK) == '0)
               && (x_q < X_ACT) && (y_q < Y_ACT);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        err_d   = err_q;
        wr_d    = 1'b0;
        oaddr_d = oaddr_q;
        odata_d = odata_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fr_start && en) begin
                    state_d = ST_ACTIVE;
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (href) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        hi_d = px_data;
                    end else begin
                        if (x_q != X_MAX) x_d = x_q + 1'b1;
                        if (keep) begin
                            if (addr_q == CAP_A) begin
                                err_d = 1'b1;
                            end else begin
                                wr_d    = 1'b1;
                                oaddr_d = addr_q[AW-1:0];
                                odata_d = conv_pix;
                                addr_d  = addr_q + 1'b1;
                            end
                        end
                    end
                end
                // line end is folded in before frame end so y is final
                if (ln_end) begin
                    if (phase_q || (x_q != X_ACT)) err_d = 1'b1;
                    if (y_q != Y_MAX) y_d = y_q + 1'b1;
                    x_d     = '0;
                    phase_d = 1'b0;
                end
                if (fr_end) begin
                    if (y_d != Y_ACT) err_d = 1'b1;
                    done_d  = 1'b1;
                    ferr_d  = err_d;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vs_q    <= 1'b0;
            hr_q    <= 1'b0;
            phase_q <= 1'b0;
            hi_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            oaddr_q <= '0;
            odata_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= vsync;
            hr_q    <= href;
            phase_q <= phase_d;
            hi_q    <= hi_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign mem_px_addr = oaddr_q;
    assign mem_px_data = odata_q;
    assign px_wr       = wr_q;
    assign frame_done  = done_q;
    assign frame_err   = ferr_q;

endmodule

// File: tb/tb_cam_capture_px.sv
// Directed bench for cam_capture_px across three geometry/format builds.
// Inst 0: RGB332 4x2, inst 1: RGB565 8x4 decimated by 2, inst 2: RGB444 4x2.
module tb_cam_capture_px;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic        rst_s [3];
    logic        vs    [3];
    logic        hr    [3];
    logic        en_s  [3];
    logic [7:0]  pd    [3];
    logic [14:0] addr_o[3];
    logic        wr_o  [3];
    logic        fd_o  [3];
    logic        fe_o  [3];
    logic [7:0]  d0;
    logic [15:0] d1;
    logic [11:0] d2;

    cam_capture_px #(.AW(15), .DW(8), .H_ACT(4), .V_ACT(2), .DEC_LOG2(0)) u0 (
        .pclk(pclk), .rst(rst_s[0]), .vsync(vs[0]), .href(hr[0]),
        .px_data(pd[0]), .en(en_s[0]), .mem_px_addr(addr_o[0]),
        .mem_px_data(d0), .px_wr(wr_o[0]), .frame_done(fd_o[0]),
        .frame_err(fe_o[0]));

    cam_capture_px #(.AW(15), .DW(16), .H_ACT(8), .V_ACT(4), .DEC_LOG2(1)) u1 (
        .pclk(pclk), .rst(rst_s[1]), .vsync(vs[1]), .href(hr[1]),
        .px_data(pd[1]), .en(en_s[1]), .mem_px_addr(addr_o[1]),
        .mem_px_data(d1), .px_wr(wr_o[1]), .frame_done(fd_o[1]),
        .frame_err(fe_o[1]));

    cam_capture_px #(.AW(15), .DW(12), .H_ACT(4), .V_ACT(2), .DEC_LOG2(0)) u2 (
        .pclk(pclk), .rst(rst_s[2]), .vsync(vs[2]), .href(hr[2]),
        .px_data(pd[2]), .en(en_s[2]), .mem_px_addr(addr_o[2]),
        .mem_px_data(d2), .px_wr(wr_o[2]), .frame_done(fd_o[2]),
        .frame_err(fe_o[2]));

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int          wr_cnt[3] = '{0, 0, 0};
    int          fd_cnt[3] = '{0, 0, 0};
    logic        fd_err[3] = '{1'b0, 1'b0, 1'b0};
    int          fd_cyc[3] = '{0, 0, 0};
    logic [14:0] wa[3][256];
    logic [15:0] wd[3][256];
    int          wc[3][256];
    int          b2cyc[3];
    int          vcyc[3];

    function automatic logic [15:0] dout(input int k);
        case (k)
            0:       return {8'h00, d0};
            1:       return d1;
            default: return {4'h0, d2};
        endcase
    endfunction

    always @(negedge pclk) begin
        for (int k = 0; k < 3; k++) begin
            if (wr_o[k]) begin
                if (wr_cnt[k] < 256) begin
                    wa[k][wr_cnt[k]] = addr_o[k];
                    wd[k][wr_cnt[k]] = dout(k);
                    wc[k][wr_cnt[k]] = cyc;
                end
                wr_cnt[k] = wr_cnt[k] + 1;
            end
            if (fd_o[k]) begin
                fd_cnt[k] = fd_cnt[k] + 1;
                fd_err[k] = fe_o[k];
                fd_cyc[k] = cyc;
            end
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge pclk);
    endtask

    task automatic chk_idle_outs(input int k, input string tag);
        chk({tag, " addr"}, 32'(addr_o[k]), 32'h0);
        chk({tag, " data"}, 32'(dout(k)), 32'h0);
        chk({tag, " px_wr"}, 32'(wr_o[k]), 32'h0);
        chk({tag, " frame_done"}, 32'(fd_o[k]), 32'h0);
        chk({tag, " frame_err"}, 32'(fe_o[k]), 32'h0);
    endtask

    function automatic logic [7:0] byte_at(input int mode, input logic [7:0] hi,
                                           input logic [7:0] lo, input int b,
                                           input int y);
        logic [15:0] v;
        v = 16'((b / 2) + 16 * y);
        if (mode == 0) return (b % 2 == 1) ? lo : hi;
        return (b % 2 == 1) ? v[7:0] : v[15:8];
    endfunction

    task automatic frame_start(input int k, input logic e);
        en_s[k] = e;
        vs[k] = 1'b1;
        hr[k] = 1'b0;
        repeat (3) tick();
        vs[k] = 1'b0;
        repeat (2) tick();
    endtask

    task automatic send_line(input int k, input int nb, input int mode,
                             input int y, input logic [7:0] hi,
                             input logic [7:0] lo);
        for (int b = 0; b < nb; b++) begin
            hr[k] = 1'b1;
            pd[k] = byte_at(mode, hi, lo, b, y);
            if (b == 1 && y == 0) b2cyc[k] = cyc;
            tick();
        end
        hr[k] = 1'b0;
        pd[k] = 8'h00;
        repeat (3) tick();
    endtask

    task automatic frame_end(input int k);
        vs[k] = 1'b1;
        vcyc[k] = cyc;
        repeat (4) tick();
    endtask

    task automatic run_frame(input int k, input logic e, input int nlines,
                             input int nb0, input int nb, input int mode,
                             input logic [7:0] hi, input logic [7:0] lo);
        frame_start(k, e);
        for (int y = 0; y < nlines; y++)
            send_line(k, (y == 0) ? nb0 : nb, mode, y, hi, lo);
        frame_end(k);
    endtask

    typedef struct {
        int          inst;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp;
    } conv_vec_t;

    conv_vec_t cv[8];
    logic [15:0] dec_exp[8];

    int wb, fb;

    initial begin
        cv[0] = '{0, 8'h07, 8'hE0, 16'h001C};
        cv[1] = '{0, 8'h00, 8'h1F, 16'h0003};
        cv[2] = '{0, 8'hFF, 8'hFF, 16'h00FF};
        cv[3] = '{0, 8'h12, 8'h34, 16'h000A};
        cv[4] = '{2, 8'h07, 8'hE0, 16'h00F0};
        cv[5] = '{2, 8'hF8, 8'h00, 16'h0F00};
        cv[6] = '{2, 8'h00, 8'h1F, 16'h000F};
        cv[7] = '{2, 8'h12, 8'h34, 16'h014A};
        dec_exp = '{16'd0, 16'd2, 16'd4, 16'd6,
                    16'd32, 16'd34, 16'd36, 16'd38};

        for (int k = 0; k < 3; k++) begin
            rst_s[k] = 1'b1;
            vs[k] = 1'b1;
            hr[k] = 1'b0;
            en_s[k] = 1'b1;
            pd[k] = 8'h00;
        end
        repeat (3) tick();
        chk_idle_outs(0, "por");
        for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
        tick();

        // reset held two cycles in the middle of line 0
        frame_start(0, 1'b1);
        hr[0] = 1'b1;
        pd[0] = 8'hF8; tick();
        pd[0] = 8'h00; tick();
        pd[0] = 8'hF8; tick();
        rst_s[0] = 1'b1;
        pd[0] = 8'h00;
        tick(); tick();
        chk_idle_outs(0, "midrst");
        rst_s[0] = 1'b0;
        tick();
        wb = wr_cnt[0];
        fb = fd_cnt[0];
        repeat (2) tick();
        hr[0] = 1'b0;
        repeat (3) tick();
        send_line(0, 8, 0, 1, 8'hF8, 8'h00);
        frame_end(0);
        chk("midrst writes", 32'(wr_cnt[0] - wb), 32'd0);
        chk("midrst frame_done", 32'(fd_cnt[0] - fb), 32'd0);

        // full-size red frame, RGB332
        wb = wr_cnt[0];
        fb = fd_cnt[0];
        run_frame(0, 1'b1, 2, 8, 8, 0, 8'hF8, 8'h00);
        chk("red writes", 32'(wr_cnt[0] - wb), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("red addr[%0d]", i), 32'(wa[0][wb + i]), 32'(i));
            chk($sformatf("red data[%0d]", i), 32'(wd[0][wb + i]), 32'h00E0);
        end
        chk("red frame_done", 32'(fd_cnt[0] - fb), 32'd1);
        chk("red frame_err", 32'(fd_err[0]), 32'd0);
        chk("red done latency", 32'(fd_cyc[0]), 32'(vcyc[0] + 1));

        // decimate by 2, pixel value x+16*y
        wb = wr_cnt[1];
        fb = fd_cnt[1];
        run_frame(1, 1'b1, 4, 16, 16, 1, 8'h00, 8'h00);
        chk("dec writes", 32'(wr_cnt[1] - wb), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("dec addr[%0d]", i), 32'(wa[1][wb + i]), 32'(i));
            chk($sformatf("dec data[%0d]", i), 32'(wd[1][wb + i]), 32'(dec_exp[i]));
        end
        chk("dec frame_done", 32'(fd_cnt[1] - fb), 32'd1);
        chk("dec frame_err", 32'(fd_err[1]), 32'd0);

        // RGB565 passthrough and write latency
        wb = wr_cnt[1];
        run_frame(1, 1'b1, 4, 16, 16, 0, 8'h12, 8'h34);
        chk("565 data", 32'(wd[1][wb]), 32'h1234);
        chk("565 wr latency", 32'(wc[1][wb]), 32'(b2cyc[1] + 1));
        chk("565 frame_err", 32'(fd_err[1]), 32'd0);

        // conversion table, first write of each frame
        for (int v = 0; v < 8; v++) begin
            wb = wr_cnt[cv[v].inst];
            run_frame(cv[v].inst, 1'b1, 2, 8, 8, 0, cv[v].hi, cv[v].lo);
            chk($sformatf("conv[%0d] data", v), 32'(wd[cv[v].inst][wb]),
                32'(cv[v].exp));
            chk($sformatf("conv[%0d] writes", v),
                32'(wr_cnt[cv[v].inst] - wb), 32'd8);
        end

        // stray byte after three pixels on line 0
        wb = wr_cnt[0];
        fb = fd_cnt[0];
        run_frame(0, 1'b1, 2, 7, 8, 0, 8'hF8, 8'h00);
        chk("stray writes", 32'(wr_cnt[0] - wb), 32'd7);
        chk("stray last addr", 32'(wa[0][wb + 6]), 32'd6);
        chk("stray frame_done", 32'(fd_cnt[0] - fb), 32'd1);
        chk("stray frame_err", 32'(fd_err[0]), 32'd1);

        // one line too many: extra line not written, error flagged
        wb = wr_cnt[0];
        run_frame(0, 1'b1, 3, 8, 8, 0, 8'hF8, 8'h00);
        chk("extra writes", 32'(wr_cnt[0] - wb), 32'd8);
        chk("extra frame_err", 32'(fd_err[0]), 32'd1);

        // capture disabled at frame start
        wb = wr_cnt[0];
        fb = fd_cnt[0];
        run_frame(0, 1'b0, 2, 8, 8, 0, 8'hF8, 8'h00);
        chk("en0 writes", 32'(wr_cnt[0] - wb), 32'd0);
        chk("en0 frame_done", 32'(fd_cnt[0] - fb), 32'd0);

        wb = wr_cnt[0];
        fb = fd_cnt[0];
        run_frame(0, 1'b1, 2, 8, 8, 0, 8'h07, 8'hE0);
        chk("en1 writes", 32'(wr_cnt[0] - wb), 32'd8);
        chk("en1 first addr", 32'(wa[0][wb]), 32'd0);
        chk("en1 frame_done", 32'(fd_cnt[0] - fb), 32'd1);
        chk("en1 frame_err", 32'(fd_err[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
